// File: rtl/ntm_matrix_feeder_pkg.sv
// ntm_matrix_feeder_pkg: shared types and default sizes for the matrix feeder.
//   state_t            feeder FSM state encoding
//   *_DEF              default element, index and address widths
//   TIMEOUT_CYCLES_DEF default acknowledge timeout (used with NTM_MATRIX_FEEDER_TIMEOUT_EN)
package ntm_matrix_feeder_pkg;

    localparam int unsigned DATA_SIZE_DEF      = 128;
    localparam int unsigned INDEX_SIZE_DEF     = 16;
    localparam int unsigned ADDR_SIZE_DEF      = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        LOAD     = 3'd2,
        PRESENT  = 3'd3,
        WAIT_ACK = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/ntm_index_counter_2d.sv
// ntm_index_counter_2d: row (l) / column (x) position counters for a row-major walk.
//   clk, rst_n      clock, async active-low reset
//   clear           synchronous return to (0,0)
//   inc_x           advance to the next column of the current row
//   next_row        advance to column 0 of the next row (wins over inc_x)
//   size_l, size_x  matrix dimensions used for the last-row/last-column flags
//   x               current column
//   last_col_c      x is the final column
//   last_row_c      l is the final row
module ntm_index_counter_2d #(
    parameter int unsigned INDEX_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  inc_x,
    input  logic                  next_row,
    input  logic [INDEX_SIZE-1:0] size_l,
    input  logic [INDEX_SIZE-1:0] size_x,
    output logic [INDEX_SIZE-1:0] x,
    output logic                  last_col_c,
    output logic                  last_row_c
);

    logic [INDEX_SIZE-1:0] l_q;
    logic [INDEX_SIZE-1:0] x_q;

    // Position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q <= '0;
            x_q <= '0;
        end else if (clear) begin
            l_q <= '0;
            x_q <= '0;
        end else if (next_row) begin
            l_q <= l_q + INDEX_SIZE'(1);
            x_q <= '0;
        end else if (inc_x) begin
            x_q <= x_q + INDEX_SIZE'(1);
        end
    end

    // Flags are only meaningful for non-zero sizes; zero-size transfers never walk
    assign last_col_c = (x_q == size_x - INDEX_SIZE'(1));
    assign last_row_c = (l_q == size_l - INDEX_SIZE'(1));
    assign x          = x_q;

endmodule

// File: rtl/ntm_matrix_feeder.sv
// ntm_matrix_feeder: streams an L x X row-major weight matrix from a synchronous-read
// buffer into the accelerator using the enable-strobe handshake.
//   CLK, RST                      clock, async active-low reset
//   START, READY, BUSY            transfer request, completion pulse, activity flag
//   SIZE_L_IN, SIZE_X_IN          row / column counts, latched on START
//   BASE_ADDR                     buffer address of element (0,0), latched on START
//   MEM_RE, MEM_ADDR, MEM_DATA    buffer read port (data one cycle after MEM_RE)
//   W_IN                          element to the accelerator, held until the next load
//   W_IN_L_ENABLE, W_IN_X_ENABLE  row-start and element-valid pulses
//   W_OUT_L_ENABLE, W_OUT_X_ENABLE accelerator row-done / element-consumed acknowledges
//   ERROR                         sticky acknowledge timeout (only with NTM_MATRIX_FEEDER_TIMEOUT_EN)
// Optional feature macro: NTM_MATRIX_FEEDER_TIMEOUT_EN adds TIMEOUT_CYCLES and ERROR.
module ntm_matrix_feeder
    import ntm_matrix_feeder_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = DATA_SIZE_DEF,
    parameter int unsigned INDEX_SIZE = INDEX_SIZE_DEF,
    parameter int unsigned ADDR_SIZE  = ADDR_SIZE_DEF
`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    output logic                  READY,
    output logic                  BUSY,
    input  logic [INDEX_SIZE-1:0] SIZE_L_IN,
    input  logic [INDEX_SIZE-1:0] SIZE_X_IN,
    input  logic [ADDR_SIZE-1:0]  BASE_ADDR,
    output logic                  MEM_RE,
    output logic [ADDR_SIZE-1:0]  MEM_ADDR,
    input  logic [DATA_SIZE-1:0]  MEM_DATA,
    output logic [DATA_SIZE-1:0]  W_IN,
    output logic                  W_IN_L_ENABLE,
    output logic                  W_IN_X_ENABLE,
    input  logic                  W_OUT_L_ENABLE,
    input  logic                  W_OUT_X_ENABLE
`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
    ,
    output logic                  ERROR
`endif
);

    state_t                state_q;
    state_t                state_d;
    logic [INDEX_SIZE-1:0] size_l_q;
    logic [INDEX_SIZE-1:0] size_x_q;
    logic [INDEX_SIZE-1:0] x;
    logic                  last_col_c;
    logic                  last_row_c;
    logic                  latch_c;
    logic                  inc_x_c;
    logic                  next_row_c;
    logic                  addr_inc_c;

`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_fire_c;
`endif

    // Row / column position tracking
    ntm_index_counter_2d #(
        .INDEX_SIZE (INDEX_SIZE)
    ) u_index (
        .clk        (CLK),
        .rst_n      (RST),
        .clear      (latch_c),
        .inc_x      (inc_x_c),
        .next_row   (next_row_c),
        .size_l     (size_l_q),
        .size_x     (size_x_q),
        .x          (x),
        .last_col_c (last_col_c),
        .last_row_c (last_row_c)
    );

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d    = state_q;
        latch_c    = 1'b0;
        inc_x_c    = 1'b0;
        next_row_c = 1'b0;
        addr_inc_c = 1'b0;
`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
        tmo_fire_c = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    latch_c = 1'b1;
                    if ((SIZE_L_IN == '0) || (SIZE_X_IN == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = LOAD;
            LOAD:    state_d = PRESENT;
            PRESENT: state_d = WAIT_ACK;
            WAIT_ACK: begin
                // Column ack outranks row ack; mismatched acks are dropped
                if (W_OUT_X_ENABLE && !last_col_c) begin
                    inc_x_c    = 1'b1;
                    addr_inc_c = 1'b1;
                    state_d    = READ;
                end else if (W_OUT_L_ENABLE && last_col_c && !last_row_c) begin
                    next_row_c = 1'b1;
                    addr_inc_c = 1'b1;
                    state_d    = READ;
                end else if (W_OUT_L_ENABLE && last_col_c && last_row_c) begin
                    state_d = DONE;
                end
`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
                else if (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_fire_c = 1'b1;
                    state_d    = IDLE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched transfer parameters and running address (MEM_ADDR is the address register)
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            size_l_q <= '0;
            size_x_q <= '0;
            MEM_ADDR <= '0;
        end else if (latch_c) begin
            size_l_q <= SIZE_L_IN;
            size_x_q <= SIZE_X_IN;
            MEM_ADDR <= BASE_ADDR;
        end else if (addr_inc_c) begin
            MEM_ADDR <= MEM_ADDR + ADDR_SIZE'(1);
        end
    end

    // Registered strobes decoded from the state being entered
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            READY         <= 1'b0;
            BUSY          <= 1'b0;
            MEM_RE        <= 1'b0;
            W_IN_X_ENABLE <= 1'b0;
            W_IN_L_ENABLE <= 1'b0;
        end else begin
            READY         <= (state_d == DONE);
            BUSY          <= (state_d != IDLE);
            MEM_RE        <= (state_d == READ);
            W_IN_X_ENABLE <= (state_d == PRESENT);
            W_IN_L_ENABLE <= (state_d == PRESENT) && (x == '0);
        end
    end

    // Element capture: buffer data is valid during LOAD
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            W_IN <= '0;
        end else if (state_q == LOAD) begin
            W_IN <= MEM_DATA;
        end
    end

`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
    // Counts cycles since PRESENT while waiting; zero outside WAIT_ACK
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_cnt_q <= '0;
        end else if (state_d == WAIT_ACK) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // Sticky timeout flag, cleared by the next accepted START
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ERROR <= 1'b0;
        end else if (latch_c) begin
            ERROR <= 1'b0;
        end else if (tmo_fire_c) begin
            ERROR <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ntm_matrix_feeder.sv
// tb_ntm_matrix_feeder: table-driven transfers plus hand sequences for ignored
// acknowledges, START while busy and mid-stream reset.
module tb_ntm_matrix_feeder;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         ready;
    logic         busy;
    logic [15:0]  size_l;
    logic [15:0]  size_x;
    logic [31:0]  base_addr;
    logic         mem_re;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data;
    logic [127:0] w_in;
    logic         l_en;
    logic         x_en;
    logic         l_ack;
    logic         x_ack;
`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
    logic         error;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ntm_matrix_feeder #(
        .DATA_SIZE      (128),
        .INDEX_SIZE     (16),
        .ADDR_SIZE      (32)
`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .CLK            (clk),
        .RST            (rst_n),
        .START          (start),
        .READY          (ready),
        .BUSY           (busy),
        .SIZE_L_IN      (size_l),
        .SIZE_X_IN      (size_x),
        .BASE_ADDR      (base_addr),
        .MEM_RE         (mem_re),
        .MEM_ADDR       (mem_addr),
        .MEM_DATA       (mem_data),
        .W_IN           (w_in),
        .W_IN_L_ENABLE  (l_en),
        .W_IN_X_ENABLE  (x_en),
        .W_OUT_L_ENABLE (l_ack),
        .W_OUT_X_ENABLE (x_ack)
`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
        ,
        .ERROR          (error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read buffer: buffer[i] = i + 0x10
    always_ff @(posedge clk) begin
        if (mem_re) mem_data <= 128'(mem_addr) + 128'h10;
    end

    typedef struct {
        int           sl;
        int           sx;
        logic [31:0]  base;
        int           delay;
        bit           both;
        int           exp_elems;
        int           exp_lrows;
        logic [127:0] exp_first;
        logic [127:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input int sl, input int sx, input logic [31:0] base);
        size_l    = 16'(sl);
        size_x    = 16'(sx);
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Wait (bounded) for the next element strobe; returns at the PRESENT negedge
    task automatic wait_xen(input string name);
        int n = 0;
        while (!x_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " arrives"}, 128'(x_en), 128'(1));
    endtask

    // One-cycle acknowledge; call when the DUT is in WAIT_ACK
    task automatic pulse_ack(input bit xa, input bit la);
        x_ack = xa;
        l_ack = la;
        @(negedge clk);
        x_ack = 1'b0;
        l_ack = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int           cyc, elems, lrows, ready_cnt, ready_cyc, mre, first_cyc, last_e, ack_wait, col, exp_rdy;
        logic [127:0] first_w, last_w;
        bit           done;
        elems = 0; lrows = 0; ready_cnt = 0; ready_cyc = -1; mre = 0;
        first_cyc = -1; last_e = 0; ack_wait = 0; done = 1'b0;
        first_w = '0; last_w = '0;
        do_start(v.sl, v.sx, v.base);
        cyc = 1;
        if (v.both) begin
            x_ack = 1'b1;
            l_ack = 1'b1;
        end
        while (!done && cyc < 400) begin
            if (mem_re) mre++;
            if (ready) begin
                ready_cnt++;
                ready_cyc = cyc;
                done = 1'b1;
            end
            if (!v.both) begin
                x_ack = 1'b0;
                l_ack = 1'b0;
                if (ack_wait > 0) begin
                    ack_wait--;
                    if (ack_wait == 0) begin
                        if (((elems - 1) % v.sx) == v.sx - 1) l_ack = 1'b1;
                        else                                  x_ack = 1'b1;
                    end
                end
            end
            if (x_en) begin
                col = elems % v.sx;
                check($sformatf("v%0d w_in[%0d]", id, elems), w_in,
                      128'(32'(v.base + 32'(elems))) + 128'h10);
                check($sformatf("v%0d l_en[%0d]", id, elems), 128'(l_en), 128'(col == 0));
                if (l_en) lrows++;
                if (elems == 0) begin
                    first_w   = w_in;
                    first_cyc = cyc;
                end
                last_w   = w_in;
                last_e   = cyc;
                elems++;
                ack_wait = v.delay + 1;
            end
            @(negedge clk);
            cyc++;
        end
        x_ack = 1'b0;
        l_ack = 1'b0;
        exp_rdy = (v.exp_elems == 0) ? 1 : last_e + v.delay + 2;
        check($sformatf("v%0d ready seen", id), 128'(done), 128'(1));
        check($sformatf("v%0d ready cycle", id), 128'(ready_cyc), 128'(exp_rdy));
        check($sformatf("v%0d elements", id), 128'(elems), 128'(v.exp_elems));
        check($sformatf("v%0d row starts", id), 128'(lrows), 128'(v.exp_lrows));
        check($sformatf("v%0d mem_re cycles", id), 128'(mre), 128'(v.exp_elems));
        if (v.exp_elems > 0) begin
            check($sformatf("v%0d first latency", id), 128'(first_cyc), 128'(3));
            check($sformatf("v%0d first w_in", id), first_w, v.exp_first);
            check($sformatf("v%0d last w_in", id), last_w, v.exp_last);
        end
        check($sformatf("v%0d ready single", id), 128'(ready), 128'(0));
        check($sformatf("v%0d idle after", id), 128'(busy), 128'(0));
    endtask

    initial begin
        int n_x, n_re;
        vecs[0] = '{2, 3, 32'h0,         2, 1'b0, 6, 2, 128'h10,          128'h15};
        vecs[1] = '{2, 2, 32'h0,         0, 1'b1, 4, 2, 128'h10,          128'h13};
        vecs[2] = '{1, 1, 32'h5,         1, 1'b0, 1, 1, 128'h15,          128'h15};
        vecs[3] = '{3, 1, 32'h20,        1, 1'b0, 3, 3, 128'h30,          128'h32};
        vecs[4] = '{1, 4, 32'hFFFF_FFFE, 0, 1'b0, 4, 1, 128'h1_0000_000E, 128'h11};
        vecs[5] = '{0, 3, 32'h0,         0, 1'b0, 0, 0, 128'h0,           128'h0};
        vecs[6] = '{2, 0, 32'h0,         0, 1'b0, 0, 0, 128'h0,           128'h0};

        rst_n = 1'b0; start = 1'b0; size_l = '0; size_x = '0; base_addr = '0;
        l_ack = 1'b0; x_ack = 1'b0;
        #1;
        check("reset ready", 128'(ready), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset mem_re", 128'(mem_re), 128'(0));
        check("reset mem_addr", 128'(mem_addr), 128'(0));
        check("reset w_in", w_in, 128'(0));
        check("reset enables", 128'({l_en, x_en}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Mismatched acknowledges are dropped; START while busy is ignored
        do_start(1, 4, 32'h100);
        wait_xen("seqB e0");
        check("seqB w0", w_in, 128'h110);
        @(negedge clk);
        l_ack = 1'b1; start = 1'b1; base_addr = 32'h999; size_x = 16'd1;
        @(negedge clk);
        l_ack = 1'b0; start = 1'b0;
        n_x = 0; n_re = 0;
        for (int k = 0; k < 5; k++) begin
            if (x_en) n_x++;
            if (mem_re) n_re++;
            @(negedge clk);
        end
        check("seqB l_ack midrow no strobe", 128'(n_x + n_re), 128'(0));
        check("seqB still busy", 128'(busy), 128'(1));
        check("seqB w_in held", w_in, 128'h110);
        for (int k = 1; k < 4; k++) begin
            pulse_ack(1'b1, 1'b0);
            wait_xen($sformatf("seqB e%0d", k));
            check($sformatf("seqB w%0d", k), w_in, 128'(32'h110 + 32'(k)));
            check($sformatf("seqB l_en%0d", k), 128'(l_en), 128'(0));
            @(negedge clk);
        end
        pulse_ack(1'b1, 1'b0);
        n_re = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_re || ready) n_re++;
            @(negedge clk);
        end
        check("seqB x_ack last col ignored", 128'(n_re), 128'(0));
        pulse_ack(1'b0, 1'b1);
        check("seqB ready", 128'(ready), 128'(1));
        @(negedge clk);

        // Reset during the second element aborts silently; restart from BASE_ADDR
        do_start(2, 2, 32'h40);
        wait_xen("seqC e0");
        check("seqC w0", w_in, 128'h50);
        @(negedge clk);
        pulse_ack(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("seqC rst outputs", 128'({ready, busy, mem_re, l_en, x_en}), 128'(0));
        check("seqC rst mem_addr", 128'(mem_addr), 128'(0));
        check("seqC rst w_in", w_in, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n_re = 0;
        for (int k = 0; k < 4; k++) begin
            if (ready || busy) n_re++;
            @(negedge clk);
        end
        check("seqC quiet after reset", 128'(n_re), 128'(0));
        do_start(2, 2, 32'h40);
        wait_xen("seqC r0");
        check("seqC restart w0", w_in, 128'h50);
        check("seqC restart l_en", 128'(l_en), 128'(1));
        @(negedge clk);
        pulse_ack(1'b1, 1'b0);
        wait_xen("seqC r1");
        check("seqC w1", w_in, 128'h51);
        @(negedge clk);
        pulse_ack(1'b0, 1'b1);
        wait_xen("seqC r2");
        check("seqC w2", w_in, 128'h52);
        check("seqC row2 l_en", 128'(l_en), 128'(1));
        @(negedge clk);
        pulse_ack(1'b1, 1'b0);
        wait_xen("seqC r3");
        check("seqC w3", w_in, 128'h53);
        @(negedge clk);
        pulse_ack(1'b0, 1'b1);
        check("seqC ready", 128'(ready), 128'(1));
        @(negedge clk);

`ifdef NTM_MATRIX_FEEDER_TIMEOUT_EN
        // No acknowledge: ERROR eight cycles after PRESENT, cleared by next START
        do_start(1, 1, 32'h0);
        wait_xen("seqT e0");
        for (int k = 0; k < 7; k++) @(negedge clk);
        check("seqT no error yet", 128'(error), 128'(0));
        @(negedge clk);
        check("seqT error", 128'(error), 128'(1));
        check("seqT idle", 128'(busy), 128'(0));
        check("seqT no ready", 128'(ready), 128'(0));
        do_start(1, 1, 32'h0);
        check("seqT error cleared", 128'(error), 128'(0));
        wait_xen("seqT e1");
        @(negedge clk);
        pulse_ack(1'b0, 1'b1);
        check("seqT ready", 128'(ready), 128'(1));
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
